player_ship_ctrl: RTL

Next-generation player controller for the shooter game. It owns the player's horizontal position, hit points and life state (alive / invulnerable / dead), and a parametrised pool of NUM_PROJ player projectiles with fire cooldown. It sits between the debounced button inputs plus step-pulse generator, and the collision and VGA drawing logic, which consume positions and sizes.

---
 rtl/player_pkg.sv | 33 +++
 rtl/player_ship_ctrl_proj_slot.sv | 42 ++++
 rtl/player_ship_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared types and widths for the player ship controller: life-state enum,
// coordinate widths, projectile slot record and saturating x arithmetic.
package player_pkg;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } player_state_e;

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } proj_slot_t;

  // Clamp at zero instead of wrapping below it.
  function automatic logic [X_W-1:0] sat_sub(input logic [X_W-1:0] a,
                                             input logic [X_W-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  // Clamp at lim; assumes lim >= b.
  function automatic logic [X_W-1:0] sat_add(input logic [X_W-1:0] a,
                                             input logic [X_W-1:0] b,
                                             input logic [X_W-1:0] lim);
    return (a > lim - b) ? lim : a + b;
  endfunction

endpackage

// File: rtl/player_ship_ctrl_proj_slot.sv
// One player projectile register: spawn into an empty slot, kill on clear,
// otherwise climb PROJ_STEP pixels per step pulse until it leaves the top.
module proj_slot
  import player_pkg::*;
#(
  parameter int unsigned PROJ_STEP = 6
) (
  input  logic           clk_master,
  input  logic           rst,
  input  logic           step_pulse,
  input  logic           spawn_i,
  input  logic           clear_i,
  input  logic [X_W-1:0] spawn_x_i,
  input  logic [Y_W-1:0] spawn_y_i,
  output proj_slot_t     slot_o
);

  proj_slot_t slot_q, slot_d;

  // A clear only affects a live slot, so a spawn into an idle slot always wins.
  always_comb begin
    slot_d = slot_q;
    if (clear_i && slot_q.active) begin
      slot_d.active = 1'b0;
    end else if (spawn_i) begin
      slot_d.active = 1'b1;
      slot_d.x      = spawn_x_i;
      slot_d.y      = spawn_y_i;
    end else if (step_pulse && slot_q.active) begin
      if (slot_q.y < Y_W'(PROJ_STEP)) slot_d.active = 1'b0;
      else                            slot_d.y      = slot_q.y - Y_W'(PROJ_STEP);
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/player_ship_ctrl.sv
// Player ship controller: position, hit points, ALIVE/INVULN/DEAD state and a
// projectile pool. Define PLAYER_FIRE_EDGE_EN for one shot per button press.
module player_ship_ctrl
  import player_pkg::*;
#(
  parameter int unsigned SCREEN_W      = 640,
  parameter int unsigned PLAYER_W      = 32,
  parameter int unsigned PLAYER_H      = 16,
  parameter int unsigned PLAYER_Y      = 440,
  parameter int unsigned START_X       = 304,
  parameter int unsigned STEP          = 4,
  parameter int unsigned NUM_PROJ      = 3,
  parameter int unsigned PROJ_W        = 4,
  parameter int unsigned PROJ_H        = 8,
  parameter int unsigned PROJ_STEP     = 6,
  parameter int unsigned MAX_HP        = 3,
  parameter int unsigned HP_W          = 2,
  parameter int unsigned INVULN_STEPS  = 60,
  parameter int unsigned FIRE_COOLDOWN = 15
) (
  input  logic                    clk_master,
  input  logic                    rst,
  input  logic                    step_pulse,
  input  logic                    mv_left,
  input  logic                    mv_right,
  input  logic                    fire,
  input  logic                    player_hit,
  input  logic [NUM_PROJ-1:0]     proj_clear,
  output logic [X_W-1:0]          player_x,
  output logic [Y_W-1:0]          player_y,
  output logic [X_W-1:0]          player_w,
  output logic [Y_W-1:0]          player_h,
  output logic [NUM_PROJ-1:0]     proj_active,
  output logic [X_W*NUM_PROJ-1:0] proj_x,
  output logic [Y_W*NUM_PROJ-1:0] proj_y,
  output logic [X_W-1:0]          proj_w,
  output logic [Y_W-1:0]          proj_h,
  output logic [HP_W-1:0]         player_hp,
  output logic                    invuln,
  output logic                    game_over
);

  localparam logic [1:0] ST_ALIVE  = 2'(ALIVE);
  localparam logic [1:0] ST_INVULN = 2'(INVULN);
  localparam logic [1:0] ST_DEAD   = 2'(DEAD);

  localparam int unsigned CD_W     = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam int unsigned INV_W    = (INVULN_STEPS > 1) ? $clog2(INVULN_STEPS + 1) : 1;
  localparam int unsigned MAX_X    = SCREEN_W - PLAYER_W;
  localparam int unsigned SPAWN_DX = PLAYER_W / 2 - PROJ_W / 2;
  localparam int unsigned SPAWN_Y  = PLAYER_Y - PROJ_H;

  logic [1:0]          state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [CD_W-1:0]     cd_q, cd_d;
  logic [INV_W-1:0]    inv_q, inv_d;
  logic                invuln_q, game_over_q;
  logic                fire_req_c;
  logic                any_free_c;
  logic [NUM_PROJ-1:0] free_oh_c, spawn_oh_c, active_c;
  logic [X_W-1:0]      spawn_x_c;
  proj_slot_t          slots [NUM_PROJ];

`ifdef PLAYER_FIRE_EDGE_EN
  // A rising edge is held pending until the next step pulse consumes it.
  logic fire_prev_q, fire_pend_q;
  assign fire_req_c = fire_pend_q | (fire & ~fire_prev_q);

  always_ff @(posedge clk_master) begin
    if (rst) begin
      fire_prev_q <= 1'b0;
      fire_pend_q <= 1'b0;
    end else begin
      fire_prev_q <= fire;
      fire_pend_q <= fire_req_c & ~step_pulse;
    end
  end
`else
  assign fire_req_c = fire;
`endif

  // Lowest-index inactive slot, one-hot.
  always_comb begin
    free_oh_c  = '0;
    any_free_c = 1'b0;
    for (int i = 0; i < int'(NUM_PROJ); i++) begin
      if (!active_c[i] && !any_free_c) begin
        free_oh_c[i] = 1'b1;
        any_free_c   = 1'b1;
      end
    end
  end

  assign spawn_x_c = x_q + X_W'(SPAWN_DX);

  // Step-pulse work uses the pre-hit state; hits are taken on any cycle.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    hp_d       = hp_q;
    cd_d       = cd_q;
    inv_d      = inv_q;
    spawn_oh_c = '0;

    if (step_pulse) begin
      if (cd_q != '0) begin
        cd_d = cd_q - CD_W'(1);
      end else if (fire_req_c && state_q != ST_DEAD && any_free_c) begin
        spawn_oh_c = free_oh_c;
        cd_d       = CD_W'(FIRE_COOLDOWN);
      end

      if (state_q != ST_DEAD && mv_left != mv_right) begin
        x_d = mv_left ? sat_sub(x_q, X_W'(STEP))
                      : sat_add(x_q, X_W'(STEP), X_W'(MAX_X));
      end

      if (state_q == ST_INVULN) begin
        inv_d = inv_q - INV_W'(1);
        if (inv_d == '0) state_d = ST_ALIVE;
      end
    end

    if (player_hit && state_q == ST_ALIVE) begin
      hp_d = hp_q - HP_W'(1);
      if (hp_d == '0) begin
        state_d = ST_DEAD;
      end else begin
        state_d = ST_INVULN;
        inv_d   = INV_W'(INVULN_STEPS);
      end
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q     <= ST_ALIVE;
      x_q         <= X_W'(START_X);
      hp_q        <= HP_W'(MAX_HP);
      cd_q        <= '0;
      inv_q       <= '0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      hp_q        <= hp_d;
      cd_q        <= cd_d;
      inv_q       <= inv_d;
      invuln_q    <= (state_d == ST_INVULN);
      game_over_q <= (state_d == ST_DEAD);
    end
  end

  for (genvar g = 0; g < int'(NUM_PROJ); g++) begin : g_slot
    proj_slot #(
      .PROJ_STEP(PROJ_STEP)
    ) u_slot (
      .clk_master(clk_master),
      .rst       (rst),
      .step_pulse(step_pulse),
      .spawn_i   (spawn_oh_c[g]),
      .clear_i   (proj_clear[g]),
      .spawn_x_i (spawn_x_c),
      .spawn_y_i (Y_W'(SPAWN_Y)),
      .slot_o    (slots[g])
    );

    assign active_c[g]               = slots[g].active;
    assign proj_x[X_W*g +: X_W]      = slots[g].x;
    assign proj_y[Y_W*g +: Y_W]      = slots[g].y;
  end

  assign proj_active = active_c;
  assign player_x    = x_q;
  assign player_hp   = hp_q;
  assign invuln      = invuln_q;
  assign game_over   = game_over_q;
  assign player_y    = Y_W'(PLAYER_Y);
  assign player_w    = X_W'(PLAYER_W);
  assign player_h    = Y_W'(PLAYER_H);
  assign proj_w      = X_W'(PROJ_W);
  assign proj_h      = Y_W'(PROJ_H);

endmodule
